multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Main control FSM for a multicycle RISC-style datapath. Sequences
//   fetch / decode / memory / ALU / branch steps and drives the datapath
//   mux selects and write enables for each step. Any memory wait that
//   runs for TIMEOUT_CYCLES cycles lands in a sticky TRAP state that
//   only rst leaves.
//
//   Optional feature: define MULDIV_EN to add a multiply/divide handshake
//   (md_start out, md_done in) and the MD_WAIT state.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   opcode[6:0]         instruction bits [6:0] (held by the IR)
//   funct7[6:0]         instruction bits [31:25]
//   mem_ready           memory access completes this cycle
//   alu_zero            ALU zero flag (used by PC logic, not here)
//   pc_write .. trap    1-bit datapath controls
//   alu_src_b[1:0]      00 reg, 01 const 4, 10 imm
//   alu_op[1:0]         00 add, 01 sub/compare, 10 funct-decoded
//   state[3:0]          current FSM state code (debug)
//   md_start / md_done  multiply/divide handshake (MULDIV_EN only)
//
// Handshake: memory is requested by holding mem_read/mem_write with iord
// for as many cycles as needed; the cycle in which mem_ready=1 is the
// completing cycle and the FSM moves on at the following edge. mem_ready
// is ignored outside FETCH, MEM_RD and MEM_WR.
module multicycle_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [6:0] funct7,
    input  logic       mem_ready,
    input  logic       alu_zero,
`ifdef MULDIV_EN
    input  logic       md_done,
    output logic       md_start,
`endif
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       ir_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic       trap,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALU_WB   = 4'd8,
        S_BRANCH   = 4'd9,
        S_MD_WAIT  = 4'd10,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [7:0] CNT_LAST  = 8'(TIMEOUT_CYCLES - 1);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_wait_cnt;
    logic       w_waiting;   // current state is a guarded wait state
    logic       w_ready;     // completion input relevant to that state
    logic       w_expired;   // this cycle would be wait number TIMEOUT_CYCLES

    // alu_zero is routed to the PC logic elsewhere; funct7 only matters
    // with MULDIV_EN. Collected here so neither is a dangling input.
    logic w_unused;
    assign w_unused = alu_zero ^ (^funct7);

    assign state = r_state;

    always_comb begin
        w_waiting = 1'b0;
        w_ready   = mem_ready;
        case (r_state)
            S_FETCH, S_MEM_RD, S_MEM_WR: w_waiting = 1'b1;
`ifdef MULDIV_EN
            S_MD_WAIT: begin
                w_waiting = 1'b1;
                w_ready   = md_done;
            end
`endif
            default: w_waiting = 1'b0;
        endcase
    end

    assign w_expired = w_waiting && !w_ready && (r_wait_cnt == CNT_LAST);

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:    if (w_expired) w_next = S_TRAP;
                        else if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: w_next = S_MEM_ADDR;
`ifdef MULDIV_EN
                    OP_R:      w_next = (funct7 == 7'b0000001) ? S_MD_WAIT : S_EXEC_R;
`else
                    OP_R:      w_next = S_EXEC_R;
`endif
                    OP_I:      w_next = S_EXEC_I;
                    OP_BRANCH: w_next = S_BRANCH;
                    default:   w_next = S_TRAP;
                endcase
            end
            // The IR still holds the instruction, so opcode picks load/store.
            S_MEM_ADDR: w_next = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (w_expired) w_next = S_TRAP;
                        else if (mem_ready) w_next = S_MEM_WB;
            S_MEM_WB:   w_next = S_FETCH;
            S_MEM_WR:   if (w_expired) w_next = S_TRAP;
                        else if (mem_ready) w_next = S_FETCH;
            S_EXEC_R:   w_next = S_ALU_WB;
            S_EXEC_I:   w_next = S_ALU_WB;
            S_ALU_WB:   w_next = S_FETCH;
            S_BRANCH:   w_next = S_FETCH;
`ifdef MULDIV_EN
            S_MD_WAIT:  if (w_expired) w_next = S_TRAP;
                        else if (md_done) w_next = S_ALU_WB;
`endif
            S_TRAP:     w_next = S_TRAP;
            default:    w_next = S_TRAP;
        endcase
    end

    // Outputs. rst gates everything combinationally so no enable can be
    // seen while reset is held, even though FETCH would request memory.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        trap          = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
`ifdef MULDIV_EN
        md_start      = 1'b0;
`endif
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE:   alu_src_b = 2'b10;
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                end
                S_EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                S_EXEC_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_op    = 2'b10;
                end
                S_ALU_WB:   reg_write = 1'b1;
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                end
`ifdef MULDIV_EN
                // Counter is zero only in the first MD_WAIT cycle.
                S_MD_WAIT:  md_start = (r_wait_cnt == 8'd0);
`endif
                S_TRAP:     trap = 1'b1;
                default:    trap = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Wait counter: zeroed on every state change, so it starts at 0 on
    // entry to each wait state and counts the not-ready cycles spent there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= 8'd0;
        end else if (w_next != r_state) begin
            r_wait_cnt <= 8'd0;
        end else if (w_waiting && !w_ready) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl. Two instances share all inputs:
// u_dut uses the default timeout, u_dut_to uses TIMEOUT_CYCLES=4.
module tb_multicycle_ctrl;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic [6:0] funct7;
    logic       mem_ready;
    logic       alu_zero;
    logic       md_done;

    logic       pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write;
    logic       reg_write, mem_to_reg, alu_src_a, trap;
    logic [1:0] alu_src_b, alu_op;
    logic [3:0] state;
    logic       md_start;

    logic       t_pc_write, t_pc_write_cond, t_ir_write, t_iord, t_mem_read, t_mem_write;
    logic       t_reg_write, t_mem_to_reg, t_alu_src_a, t_trap;
    logic [1:0] t_alu_src_b, t_alu_op;
    logic [3:0] t_state;
    logic       t_md_start;

    int n_total;
    int n_bad;
    logic [3:0] exp_q[$];

`ifndef MULDIV_EN
    // Handshake nets exist only with MULDIV_EN; tie them off otherwise.
    assign md_start   = 1'b0;
    assign t_md_start = 1'b0;
`endif

    multicycle_ctrl u_dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct7(funct7),
        .mem_ready(mem_ready), .alu_zero(alu_zero),
`ifdef MULDIV_EN
        .md_done(md_done), .md_start(md_start),
`endif
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .trap(trap), .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state)
    );

    multicycle_ctrl #(.TIMEOUT_CYCLES(4)) u_dut_to (
        .clk(clk), .rst(rst), .opcode(opcode), .funct7(funct7),
        .mem_ready(mem_ready), .alu_zero(alu_zero),
`ifdef MULDIV_EN
        .md_done(md_done), .md_start(t_md_start),
`endif
        .pc_write(t_pc_write), .pc_write_cond(t_pc_write_cond), .ir_write(t_ir_write),
        .iord(t_iord), .mem_read(t_mem_read), .mem_write(t_mem_write),
        .reg_write(t_reg_write), .mem_to_reg(t_mem_to_reg), .alu_src_a(t_alu_src_a),
        .trap(t_trap), .alu_src_b(t_alu_src_b), .alu_op(t_alu_op), .state(t_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        mem_ready = 1'b1;
        #1;
        check("rst_state", 16'(state), 16'd0);
        check("rst_mem_read", 16'(mem_read), 16'd0);
        check("rst_ir_pc_write", 16'({ir_write, pc_write}), 16'd0);
        check("rst_trap", 16'(trap), 16'd0);
        step();
        rst       = 1'b0;
        mem_ready = 1'b0;
        #1;
        check("post_rst_state", 16'(state), 16'd0);
        check("post_rst_mem_read", 16'(mem_read), 16'd1);
    endtask

    // Runs from FETCH (mem_ready=1 on the first cycle) through the states
    // queued in exp_q; ends without stepping past the last entry.
    task automatic run_trace(input string name, input logic [6:0] op);
        logic [3:0] e;
        opcode    = op;
        mem_ready = 1'b1;
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({name, "_state"}, 16'(state), 16'(e));
            check({name, "_reg_write"}, 16'(reg_write), 16'(e == 4'd8));
            check({name, "_pc_write_cond"}, 16'(pc_write_cond), 16'(e == 4'd9));
            if (exp_q.size() > 0) begin
                step();
                mem_ready = 1'b0;
                #1;
            end
        end
        mem_ready = 1'b0;
    endtask

    // Fetch + decode + address for a memory op; leaves the FSM in the
    // cycle after MEM_ADDR (MEM_RD or MEM_WR).
    task automatic to_mem_stage(input logic [6:0] op);
        opcode    = op;
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        step();
        #0;
        check("mem_addr_state", 16'(state), 16'd2);
        check("mem_addr_srcs", 16'({alu_src_a, alu_src_b, alu_op}), 16'b1_10_00);
        step();
    endtask

    initial begin
        n_total   = 0;
        n_bad     = 0;
        opcode    = 7'd0;
        funct7    = 7'd0;
        mem_ready = 1'b0;
        alu_zero  = 1'b0;
        md_done   = 1'b0;
        rst       = 1'b0;

        do_reset();

        // R-type: 0,1,6,8,0
        exp_q = '{4'd0, 4'd1, 4'd6, 4'd8, 4'd0};
        run_trace("rtype", 7'b0110011);

        // I-type: 0,1,7,8,0
        exp_q = '{4'd0, 4'd1, 4'd7, 4'd8, 4'd0};
        run_trace("itype", 7'b0010011);

        // Branch: 0,1,9,0 with pc_write_cond only in 9
        exp_q = '{4'd0, 4'd1, 4'd9, 4'd0};
        run_trace("branch", 7'b1100011);

        // Fetch cycle controls with mem_ready high
        mem_ready = 1'b1;
        #1;
        check("fetch_ctrl", 16'({ir_write, pc_write, mem_read, iord, alu_src_a, alu_src_b, alu_op}),
              16'b1_1_1_0_0_01_00);
        mem_ready = 1'b0;
        #1;

        // Load with mem_ready low 3 cycles in MEM_RD
        to_mem_stage(7'b0000011);
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            #1;
            check("load_rd_state", 16'(state), 16'd3);
            check("load_rd_ctrl", 16'({mem_read, iord}), 16'b11);
            if (i < 3) step();
        end
        step();
        mem_ready = 1'b0;
        #1;
        check("load_wb_state", 16'(state), 16'd4);
        check("load_wb_ctrl", 16'({reg_write, mem_to_reg, mem_read}), 16'b110);
        step();
        check("load_done_state", 16'(state), 16'd0);

        // Store, completes after one wait cycle; mem_write drops after ready
        to_mem_stage(7'b0100011);
        check("store_wr_state", 16'(state), 16'd5);
        check("store_wr_ctrl", 16'({mem_write, iord, mem_read}), 16'b110);
        mem_ready = 1'b1;
        #1;
        check("store_ready_wr", 16'(mem_write), 16'd1);
        step();
        mem_ready = 1'b0;
        #1;
        check("store_done_state", 16'(state), 16'd0);
        check("store_done_wr", 16'(mem_write), 16'd0);

        // Reset mid-write aborts asynchronously
        to_mem_stage(7'b0100011);
        check("abort_pre_wr", 16'(mem_write), 16'd1);
        #2;
        rst = 1'b1;
        #1;
        check("abort_wr_async", 16'(mem_write), 16'd0);
        check("abort_state_async", 16'(state), 16'd0);
        step();
        rst = 1'b0;
        #1;
        check("abort_clean_fetch", 16'({state, mem_read, mem_write}), 16'b0000_1_0);

`ifdef MULDIV_EN
        // Mul/div: md_start one cycle, 5 cycles in MD_WAIT, then ALU_WB
        funct7 = 7'b0000001;
        opcode = 7'b0110011;
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            md_done = (i == 4);
            #1;
            check("md_state", 16'(state), 16'd10);
            check("md_start", 16'(md_start), 16'(i == 0));
            step();
        end
        md_done = 1'b0;
        #1;
        check("md_to_alu_wb", 16'(state), 16'd8);
        step();
        funct7 = 7'd0;
`else
        // Without the mul/div option, funct7=0000001 takes the EXEC_R path
        funct7 = 7'b0000001;
        exp_q = '{4'd0, 4'd1, 4'd6, 4'd8, 4'd0};
        run_trace("md_off", 7'b0110011);
        funct7 = 7'd0;
`endif

        // Illegal opcode traps and stays trapped until reset
        opcode    = 7'b1111111;
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        check("illegal_decode", 16'(state), 16'd1);
        step();
        for (int i = 0; i < 20; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            #1;
            check("trap_hold", 16'({state, trap, mem_read, mem_write, ir_write, reg_write}),
                  16'b1111_1_0_0_0_0);
            step();
        end
        rst = 1'b1;
        #1;
        check("trap_rst_state", 16'({state, trap}), 16'b0000_0);
        step();
        rst       = 1'b0;
        mem_ready = 1'b0;
        #1;
        check("trap_rst_release", 16'({state, trap, mem_read}), 16'b0000_0_1);

        // TIMEOUT_CYCLES=4: store never acknowledged
        do_reset();
        to_mem_stage(7'b0100011);
        for (int i = 0; i < 4; i++) begin
            check("to_wr_state", 16'(t_state), 16'd5);
            check("to_wr_mem_write", 16'(t_mem_write), 16'd1);
            step();
        end
        check("to_trap_state", 16'(t_state), 16'd15);
        check("to_trap_ctrl", 16'({t_trap, t_mem_write}), 16'b10);
        check("to_default_still_wr", 16'(state), 16'd5);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
